my_serial_adder: RTL and testbench

MY_SERIAL_ADDER -- requirements
Module: my_serial_adder

---
 rtl/my_serial_adder.sv | 178 +++++++++++++++++
 tb/tb_my_serial_adder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_serial_adder.sv
// my_serial_adder: bit-serial adder, one full-adder bit per clock, LSB first.
// Operands are taken in IDLE, processed over WIDTH RUN cycles and presented
// in DONE until the consumer accepts them.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.

// Leaf gate: 2-input XOR
module my_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// Leaf gate: 2-input AND
module my_and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// Leaf gate: 2-input OR
module my_or (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

module my_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef SERIAL_ADD_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  // Single full-adder bit: propagate, generate and carry terms from gate instances
  logic fa_p, fa_s, fa_g, fa_t, fa_co;

  my_xor u_xor_p  (.a(a_sh_q[0]), .b(b_sh_q[0]), .y(fa_p));
  my_xor u_xor_s  (.a(fa_p),      .b(carry_q),   .y(fa_s));
  my_and u_and_g  (.a(a_sh_q[0]), .b(b_sh_q[0]), .y(fa_g));
  my_and u_and_t  (.a(carry_q),   .b(fa_p),      .y(fa_t));
  my_or  u_or_co  (.a(fa_g),      .b(fa_t),      .y(fa_co));

  // Next-state and next-output logic; outputs are precomputed so they come straight from flops
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = b;
          carry_d    = cin;
          cnt_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // The bit just added is the MSB: its carry-in vs carry-out gives signed overflow
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d      = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d       = carry_q ^ fa_co;
`endif
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // FSM, datapath and registered outputs; reset clears everything and abandons any operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_my_serial_adder.sv
// Testbench for my_serial_adder (WIDTH=8). Builds with or without SERIAL_ADD_OVF_EN.
module tb_my_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  my_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #10 clk = ~clk;

  // Reference: full-precision unsigned sum
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  // Reference: signed overflow means the true signed result does not fit in W bits
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  // Present operands at a negedge, let one posedge accept them, then count
  // negedges until out_valid appears (lat = -1 if it never does).
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        output int lat);
    a = ia; b = ib; cin = ic; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b, want 1 0 00 0",
               in_ready, out_valid, sum, cout);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: ovf=%b, want 0", ovf);
    end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W:0]   exp;
    int           lat;
    int           n;
    ta[0] = 8'h0F; tb[0] = 8'h01;
    ta[1] = 8'hFF; tb[1] = 8'h01;
    ta[2] = 8'h7F; tb[2] = 8'h01;
    ta[3] = 8'h80; tb[3] = 8'h80;
`ifdef SERIAL_ADD_OVF_EN
    n = 4;
`else
    n = 2;
`endif
    for (int i = 0; i < n; i++) begin
      exp = ref_add(ta[i], tb[i], 1'b0);
      run_op(ta[i], tb[i], 1'b0, lat);
      n_checks++;
      if (lat != W) begin
        n_fail++;
        $display("FAIL directed%0d_latency: %0d edges after accept, want %0d", i, lat, W);
      end
      n_checks++;
      if (sum !== exp[W-1:0] || cout !== exp[W] || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_result: sum=%h cout=%b in_ready=%b, want %h %b 0",
                 i, sum, cout, in_ready, exp[W-1:0], exp[W]);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (ovf !== ref_ovf(ta[i], tb[i], 1'b0)) begin
        n_fail++;
        $display("FAIL directed%0d_ovf: ovf=%b, want %b", i, ovf, ref_ovf(ta[i], tb[i], 1'b0));
      end
`endif
      release_op();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d_release: in_ready=%b out_valid=%b, want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    run_op(8'h55, 8'hAA, 1'b1, lat);
    n_checks++;
    if (lat != W) begin
      n_fail++;
      $display("FAIL stall_latency: %0d edges after accept, want %0d", lat, W);
    end
    // Hold off the consumer while offering operands that must be ignored
    for (int i = 0; i < 5; i++) begin
      a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sum !== 8'h00 || cout !== 1'b1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: sum=%h cout=%b out_valid=%b in_ready=%b, want 00 1 1 0",
                 i, sum, cout, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    release_op();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b sum=%h, want 1 0 00",
               in_ready, out_valid, sum);
    end
    // Nothing offered during the stall may produce a second result
    repeat (W + 3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_ghost: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b sum=%h cout=%b, want 1 0 00 0",
               in_ready, out_valid, sum, cout);
    end
    run_op(8'h03, 8'h04, 1'b0, lat);
    n_checks++;
    if (lat != W || sum !== 8'h07 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_after: lat=%0d sum=%h cout=%b, want %0d 07 0", lat, sum, cout, W);
    end
    release_op();
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   exp;
    int           lat;
    int           stall;
    int           bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      exp = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, lat);
      n_checks++;
      if (lat != W || sum !== exp[W-1:0] || cout !== exp[W]) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random%0d: a=%h b=%h cin=%b lat=%0d sum=%h cout=%b, want lat=%0d %h %b",
                   i, ra, rb, rc, lat, sum, cout, W, exp[W-1:0], exp[W]);
      end
`ifdef SERIAL_ADD_OVF_EN
      n_checks++;
      if (ovf !== ref_ovf(ra, rb, rc)) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random%0d_ovf: ovf=%b, want %b", i, ovf, ref_ovf(ra, rb, rc));
      end
`endif
      stall = int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || sum !== exp[W-1:0] || cout !== exp[W]) begin
          n_fail++;
          bad++;
          if (bad <= 10)
            $display("FAIL random%0d_stall: out_valid=%b sum=%h cout=%b, want 1 %h %b",
                     i, out_valid, sum, cout, exp[W-1:0], exp[W]);
        end
      end
      in_valid = 1'b0;
      release_op();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random%0d_release: out_valid=%b in_ready=%b, want 0 1",
                   i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
